a2d_seq: RTL

- Parametrised multi-channel A2D conversion sequencer.
- Replaces the fixed four-channel load-cell/battery/steer-pot reader at the top level with a configurable channel list.
- Drives the team's SPI master through its snd/done handshake and publishes one result register per channel.
- Integrates the battery-low comparison, with hysteresis, that the top level currently performs combinationally.

---
 rtl/a2d_seq_if.sv | 11 +
 rtl/a2d_seq.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/a2d_seq_if.sv
// Handshake between the A2D sequencer (master side) and the SPI master (slave side).
// A request is a one-cycle snd with cmd, and it completes with a one-cycle done with resp.
interface a2d_seq_if;
    logic        snd;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] resp;

    modport master (output snd, output cmd, input done, input resp);
    modport slave  (input snd, input cmd, output done, output resp);
endinterface

// File: rtl/a2d_seq.sv
// Multi-channel A2D conversion sequencer: converts each CH_MAP slot over SPI and publishes all slots at once.
// Define A2D_AVG_EN to add a per-slot (3*old + sample)/4 filter ahead of res and batt_low.
module a2d_seq #(
    parameter int                  NUM_CH     = 4,
    parameter logic [3*NUM_CH-1:0] CH_MAP     = {3'd5, 3'd4, 3'd3, 3'd0},
    parameter int                  DATA_W     = 12,
    parameter int                  BATT_IDX   = 2,
    parameter logic [DATA_W-1:0]   BATT_THRES = 12'h800,
    parameter logic [DATA_W-1:0]   BATT_HYST  = 12'h020
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     nxt,
    a2d_seq_if.master                spi,
    output logic [NUM_CH*DATA_W-1:0] res,
    output logic                     res_vld,
    output logic                     busy,
    output logic                     batt_low
);
    localparam int SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {IDLE, CNV_S, CNV_W, GAP, RD_S, RD_W, PUB} state_t;

    state_t                   state_q, state_d;
    logic [SLOT_W-1:0]        slot_q, slot_d;
    logic [DATA_W-1:0]        shadow_q [NUM_CH];
    logic [DATA_W-1:0]        shadow_d [NUM_CH];
    logic [NUM_CH*DATA_W-1:0] res_q, res_d;
    logic                     res_vld_q, res_vld_d;
    logic                     batt_low_q, batt_low_d;
    logic                     batt_next;
    logic [15:0]              slot_cmd;
    logic [DATA_W-1:0]        sample;
    logic [DATA_W-1:0]        slot_val;
    logic                     unused_resp_hi;

    assign slot_cmd       = {2'b00, CH_MAP[3*int'(slot_q) +: 3], 11'h000};
    assign sample         = spi.resp[DATA_W-1:0];
    assign unused_resp_hi = ^spi.resp[15:DATA_W];

`ifdef A2D_AVG_EN
    logic              seeded_q, seeded_d;
    logic [DATA_W-1:0] old_val;
    logic [DATA_W+1:0] filt_sum;

    // The published result is the filter state, so res_q doubles as "old".
    assign old_val  = res_q[DATA_W*int'(slot_q) +: DATA_W];
    assign filt_sum = ({2'b00, old_val} << 1) + {2'b00, old_val} + {2'b00, sample};
    assign slot_val = seeded_q ? DATA_W'(filt_sum >> 2) : sample;
`else
    assign slot_val = sample;
`endif

    if (BATT_IDX < NUM_CH) begin : g_batt
        localparam logic [DATA_W:0] CLR_LVL = {1'b0, BATT_THRES} + {1'b0, BATT_HYST};
        always_comb begin
            batt_next = batt_low_q;
            if (shadow_q[BATT_IDX] < BATT_THRES) begin
                batt_next = 1'b1;
            end else if ({1'b0, shadow_q[BATT_IDX]} >= CLR_LVL) begin
                batt_next = 1'b0;
            end
        end
    end else begin : g_no_batt
        assign batt_next = 1'b0;
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        shadow_d   = shadow_q;
        res_d      = res_q;
        res_vld_d  = 1'b0;
        batt_low_d = batt_low_q;
`ifdef A2D_AVG_EN
        seeded_d   = seeded_q;
`endif
        spi.snd    = 1'b0;
        spi.cmd    = (state_q != IDLE && state_q != PUB) ? slot_cmd : 16'h0000;
        case (state_q)
            IDLE:  if (nxt) state_d = CNV_S;
            CNV_S: begin
                spi.snd = 1'b1;
                state_d = CNV_W;
            end
            CNV_W: if (spi.done) state_d = GAP;
            GAP:   state_d = RD_S;
            RD_S:  begin
                spi.snd = 1'b1;
                state_d = RD_W;
            end
            RD_W:  if (spi.done) begin
                shadow_d[slot_q] = slot_val;
                if (slot_q == SLOT_W'(NUM_CH - 1)) begin
                    state_d = PUB;
                end else begin
                    slot_d  = slot_q + SLOT_W'(1);
                    state_d = CNV_S;
                end
            end
            PUB:   begin
                for (int i = 0; i < NUM_CH; i++) begin
                    res_d[DATA_W*i +: DATA_W] = shadow_q[i];
                end
                res_vld_d  = 1'b1;
                batt_low_d = batt_next;
                slot_d     = '0;
`ifdef A2D_AVG_EN
                seeded_d   = 1'b1;
`endif
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            shadow_q   <= '{default: '0};
            res_q      <= '0;
            res_vld_q  <= 1'b0;
            batt_low_q <= 1'b0;
`ifdef A2D_AVG_EN
            seeded_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            shadow_q   <= shadow_d;
            res_q      <= res_d;
            res_vld_q  <= res_vld_d;
            batt_low_q <= batt_low_d;
`ifdef A2D_AVG_EN
            seeded_q   <= seeded_d;
`endif
        end
    end

    assign res      = res_q;
    assign res_vld  = res_vld_q;
    assign busy     = (state_q != IDLE);
    assign batt_low = batt_low_q;
endmodule
